// File: rtl/lsb_embedder.sv
`default_nettype none
// ============================================================================
// Module      : lsb_embedder
// Description : Pops MESS_WIDTH-bit message nibbles from a FIFO and writes
//               them, EMBED_BITS at a time (LSB slice first), into the LSBs
//               of a valid/ready pixel stream. After mess_len nibbles have
//               been embedded, pixels pass through unchanged.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   1-cycle pulse, begin new message (samples mess_len)
//   mess_len     in   number of nibbles to embed
//   mess_din     in   FIFO data out
//   mess_vld     in   FIFO data out valid
//   mess_empty   in   FIFO empty
//   mess_rd_req  out  FIFO read request (1-cycle pulse)
//   pix_in       in   cover pixel
//   pix_in_vld   in   cover pixel valid
//   pix_in_rdy   out  cover pixel ready
//   pix_out      out  stego pixel (registered)
//   pix_out_vld  out  stego pixel valid
//   pix_out_rdy  in   downstream ready
//   busy         out  message embedding in progress
//   done         out  message fully embedded, sticky until next start
// Configuration
//   STEGO_SCRAMBLE_EN : when defined, each latched nibble is XORed with a
//                       4-bit LFSR (seed 4'b1001, reloaded on every accepted
//                       start, advanced once per latched nibble).
//                       Requires MESS_WIDTH <= 4.
// ============================================================================
module lsb_embedder #(
  parameter int PIX_WIDTH  = 8,
  parameter int MESS_WIDTH = 4,
  parameter int EMBED_BITS = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  mess_len,
  input  logic [MESS_WIDTH-1:0] mess_din,
  input  logic                  mess_vld,
  input  logic                  mess_empty,
  output logic                  mess_rd_req,
  input  logic [PIX_WIDTH-1:0]  pix_in,
  input  logic                  pix_in_vld,
  output logic                  pix_in_rdy,
  output logic [PIX_WIDTH-1:0]  pix_out,
  output logic                  pix_out_vld,
  input  logic                  pix_out_rdy,
  output logic                  busy,
  output logic                  done
);

  localparam int C_SLICES  = MESS_WIDTH / EMBED_BITS;
  localparam int C_K_WIDTH = (C_SLICES > 1) ? $clog2(C_SLICES) : 1;
  localparam logic [C_K_WIDTH-1:0] C_K_LAST = C_K_WIDTH'(C_SLICES - 1);
  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMBED = 3'd3,
    ST_PASS  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [C_K_WIDTH-1:0]   k_q, k_d;
  logic [MESS_WIDTH-1:0]  nibble_q, nibble_d;
  logic [PIX_WIDTH-1:0]   pix_out_q, pix_out_d;
  logic                   pix_out_vld_q, pix_out_vld_d;
  logic                   done_q, done_d;

  logic                   w_pix_accept;
  logic                   w_pass_state;
  logic [MESS_WIDTH-1:0]  w_shifted;
  logic [EMBED_BITS-1:0]  w_slice;
  logic [MESS_WIDTH-1:0]  w_key;

`ifdef STEGO_SCRAMBLE_EN
  logic [3:0] lfsr_q, lfsr_d;
  assign w_key = lfsr_q[MESS_WIDTH-1:0];
`else
  assign w_key = '0;
`endif

  // Pixels are only taken in states that can produce an output pixel; the
  // output register may still drain while the input is stalled.
  assign w_pass_state = (state_q == ST_IDLE) || (state_q == ST_PASS);
  assign pix_in_rdy   = (!pix_out_vld_q || pix_out_rdy) &&
                        (w_pass_state || (state_q == ST_EMBED));
  assign w_pix_accept = pix_in_vld && pix_in_rdy;

  // Current slice of the latched nibble, LSB slice first.
  assign w_shifted = nibble_q >> (k_q * EMBED_BITS);
  assign w_slice   = w_shifted[EMBED_BITS-1:0];

  assign pix_out     = pix_out_q;
  assign pix_out_vld = pix_out_vld_q;
  assign done        = done_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                       (state_q == ST_EMBED);

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    k_d           = k_q;
    nibble_d      = nibble_q;
    pix_out_d     = pix_out_q;
    pix_out_vld_d = pix_out_vld_q;
    done_d        = done_q;
    mess_rd_req   = 1'b0;
`ifdef STEGO_SCRAMBLE_EN
    lfsr_d        = lfsr_q;
`endif

    // Output register: load on accept, otherwise clear once consumed.
    if (w_pix_accept) begin
      pix_out_vld_d = 1'b1;
      if (state_q == ST_EMBED) begin
        pix_out_d = {pix_in[PIX_WIDTH-1:EMBED_BITS], w_slice};
      end else begin
        pix_out_d = pix_in;
      end
    end else if (pix_out_rdy) begin
      pix_out_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_PASS: begin
        if (start) begin
`ifdef STEGO_SCRAMBLE_EN
          lfsr_d = 4'b1001;
`endif
          k_d = '0;
          if (mess_len != '0) begin
            rem_d   = mess_len;
            done_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_PASS;
          end
        end
      end

      ST_FETCH: begin
        if (!mess_empty) begin
          mess_rd_req = 1'b1;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mess_vld) begin
          nibble_d = mess_din ^ w_key;
`ifdef STEGO_SCRAMBLE_EN
          lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
          k_d      = '0;
          state_d  = ST_EMBED;
        end
      end

      ST_EMBED: begin
        if (w_pix_accept) begin
          if (k_q == C_K_LAST) begin
            k_d = '0;
            // rem never wraps below zero.
            if (rem_q != '0) begin
              rem_d = rem_q - C_LEN_ONE;
            end
            if (rem_q <= C_LEN_ONE) begin
              done_d  = 1'b1;
              state_d = ST_PASS;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            k_d = k_q + C_K_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      k_q           <= '0;
      nibble_q      <= '0;
      pix_out_q     <= '0;
      pix_out_vld_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      k_q           <= k_d;
      nibble_q      <= nibble_d;
      pix_out_q     <= pix_out_d;
      pix_out_vld_q <= pix_out_vld_d;
      done_q        <= done_d;
    end
  end

`ifdef STEGO_SCRAMBLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 4'b1001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

endmodule
`default_nettype wire
